// File: rtl/uno_pkg.sv
// Shared UNO card definitions: card encoding, special values and the canonical deck order.
package uno_pkg;

   localparam int unsigned DECK_SIZE = 108;

   typedef struct packed {
      logic [1:0] colour;
      logic [3:0] value;
   } card_t;

   localparam logic [3:0] VAL_SKIP  = 4'd10;
   localparam logic [3:0] VAL_REV   = 4'd11;
   localparam logic [3:0] VAL_DRAW2 = 4'd12;
   localparam logic [3:0] VAL_WILD  = 4'd13;
   localparam logic [3:0] VAL_WILD4 = 4'd14;

   localparam card_t CARD_NONE = 6'h3F;

   // Card at position idx of the unshuffled deck: per colour one 0 then pairs of 1..12,
   // followed by four wilds and four wild-draw-fours.
   function automatic card_t canonical_card(input logic [6:0] idx);
      card_t       c;
      int unsigned k;
      int unsigned pos;
      k = {25'd0, idx};
      if (k < 100) begin
         c.colour = 2'(k / 25);
         pos      = k % 25;
         c.value  = 4'((pos + 1) / 2);
      end else if (k < 104) begin
         c.colour = 2'd0;
         c.value  = VAL_WILD;
      end else begin
         c.colour = 2'd0;
         c.value  = VAL_WILD4;
      end
      return c;
   endfunction

endpackage

// File: rtl/uno_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed load; a zero seed maps to the default.
module uno_lfsr16 #(
   parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
   parameter logic [15:0] TAPS         = 16'hB400
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [15:0] i_seed,
   input  logic        i_en,
   output logic [15:0] o_state
);

   logic [15:0] state_q;

   // Load has priority over advance; the all-zero state would lock up, so it is never loaded.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= DEFAULT_SEED;
      end else if (i_load) begin
         state_q <= (i_seed == 16'd0) ? DEFAULT_SEED : i_seed;
      end else if (i_en) begin
         state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? TAPS : 16'd0);
      end
   end

   assign o_state = state_q;

endmodule

// File: rtl/uno_deck_dealer.sv
// Draw pile for the UNO game: builds the canonical deck, Fisher-Yates shuffles it in place,
// then serves one card per draw request from the top of the pile.
module uno_deck_dealer
   import uno_pkg::*;
#(
   parameter int unsigned CARD_W       = 6,
   parameter int unsigned LFSR_W       = 16,
   parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
   parameter bit          SHUFFLE_EN   = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_draw,
   output logic [CARD_W-1:0] o_card,
   output logic              o_card_valid,
   output logic              o_underflow,
   output logic [6:0]        o_remaining,
   output logic              o_busy,
   output logic              o_ready
);

   typedef enum logic [1:0] {StIdle, StFill, StShuffle, StReady} state_e;

   localparam logic [6:0] LAST_IDX = 7'(DECK_SIZE - 1);
   localparam logic [6:0] FULL_CNT = 7'(DECK_SIZE);

   state_e      state_q, state_d;
   logic [6:0]  idx_q, idx_d;
   logic [6:0]  rem_q, rem_d;
   card_t       card_q, card_d;
   logic        valid_q, valid_d;
   logic        uflow_q, uflow_d;

   logic        fill_we;
   logic        swap_en;
   logic        lfsr_load;
   logic        lfsr_en;
   logic [15:0] lfsr_state;
   logic [6:0]  rnd;
   card_t       top_card;
   card_t       pile [DECK_SIZE];
   logic        unused_lfsr;

   // Smallest all-ones mask covering i, so the random pick needs few retries.
   function automatic logic [6:0] mask_for(input logic [6:0] i);
      if (i > 7'd63)      return 7'h7F;
      else if (i > 7'd31) return 7'h3F;
      else if (i > 7'd15) return 7'h1F;
      else if (i > 7'd7)  return 7'h0F;
      else if (i > 7'd3)  return 7'h07;
      else if (i > 7'd1)  return 7'h03;
      else                return 7'h01;
   endfunction

   uno_lfsr16 #(
      .DEFAULT_SEED(DEFAULT_SEED),
      .TAPS        (16'hB400)
   ) u_lfsr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (lfsr_load),
      .i_seed (i_seed),
      .i_en   (lfsr_en),
      .o_state(lfsr_state)
   );

   assign rnd         = lfsr_state[6:0] & mask_for(idx_q);
   assign unused_lfsr = ^lfsr_state[15:7];
   assign top_card    = pile[rem_q - 7'd1];

   // Next-state, pile write strobes and draw handling; i_start overrides everything else.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rem_d     = rem_q;
      card_d    = card_q;
      valid_d   = 1'b0;
      uflow_d   = 1'b0;
      fill_we   = 1'b0;
      swap_en   = 1'b0;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      if (i_start) begin
         state_d   = StFill;
         idx_d     = 7'd0;
         rem_d     = 7'd0;
         card_d    = CARD_NONE;
         lfsr_load = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: state_d = StIdle;
            StFill: begin
               fill_we = 1'b1;
               if (idx_q == LAST_IDX) begin
                  if (SHUFFLE_EN) begin
                     state_d = StShuffle;
                     idx_d   = LAST_IDX;
                  end else begin
                     state_d = StReady;
                     rem_d   = FULL_CNT;
                  end
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
            StShuffle: begin
               lfsr_en = 1'b1;
               // Out-of-range picks are rejected and retried with the next LFSR value.
               if (rnd <= idx_q) begin
                  swap_en = 1'b1;
                  if (idx_q == 7'd1) begin
                     state_d = StReady;
                     rem_d   = FULL_CNT;
                  end else begin
                     idx_d = idx_q - 7'd1;
                  end
               end
            end
            StReady: begin
               if (i_draw) begin
                  if (rem_q != 7'd0) begin
                     card_d  = top_card;
                     valid_d = 1'b1;
                     rem_d   = rem_q - 7'd1;
                  end else begin
                     uflow_d = 1'b1;
                     card_d  = CARD_NONE;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         idx_q   <= 7'd0;
         rem_q   <= 7'd0;
         card_q  <= CARD_NONE;
         valid_q <= 1'b0;
         uflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         card_q  <= card_d;
         valid_q <= valid_d;
         uflow_q <= uflow_d;
      end
   end

   // Pile storage: canonical fill or in-place swap; contents need no reset.
   always_ff @(posedge i_clk) begin
      if (fill_we) begin
         pile[idx_q] <= canonical_card(idx_q);
      end else if (swap_en) begin
         pile[idx_q] <= pile[rnd];
         pile[rnd]   <= pile[idx_q];
      end
   end

   assign o_card       = card_q;
   assign o_card_valid = valid_q;
   assign o_underflow  = uflow_q;
   assign o_remaining  = rem_q;
   assign o_busy       = (state_q == StFill) || (state_q == StShuffle);
   assign o_ready      = (state_q == StReady);

endmodule

// File: tb/tb_uno_deck_dealer.sv
// Bench for uno_deck_dealer: one unshuffled and one shuffled instance, scoreboard of expected
// draw pulses checked on the falling edge, plus a reference Fisher-Yates model.
module tb_uno_deck_dealer;

   typedef struct {
      logic       uflow;
      logic [5:0] card;
      logic [6:0] rem;
   } exp_t;

   typedef struct {
      int         n;
      logic [5:0] card;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       start = 2'b00;
   logic [1:0]       draw = 2'b00;
   logic [1:0][15:0] seed = '0;
   logic [1:0][5:0]  card;
   logic [1:0]       valid;
   logic [1:0]       uflow;
   logic [1:0][6:0]  rem;
   logic [1:0]       busy;
   logic [1:0]       ready;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t       q0[$];
   exp_t       q1[$];
   logic [5:0] cap0[$];
   logic [5:0] cap1[$];
   logic [5:0] canon [108];
   logic [5:0] mdl [108];
   logic [5:0] seq [5][108];

   always #5 clk = ~clk;

   uno_deck_dealer #(.SHUFFLE_EN(1'b0)) u_dut_canon (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start[0]),
      .i_seed      (seed[0]),
      .i_draw      (draw[0]),
      .o_card      (card[0]),
      .o_card_valid(valid[0]),
      .o_underflow (uflow[0]),
      .o_remaining (rem[0]),
      .o_busy      (busy[0]),
      .o_ready     (ready[0])
   );

   uno_deck_dealer #(.SHUFFLE_EN(1'b1)) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start[1]),
      .i_seed      (seed[1]),
      .i_draw      (draw[1]),
      .o_card      (card[1]),
      .o_card_valid(valid[1]),
      .o_underflow (uflow[1]),
      .o_remaining (rem[1]),
      .o_busy      (busy[1]),
      .o_ready     (ready[1])
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // Reference shuffle of the canonical deck for a given seed.
   task automatic run_model(input logic [15:0] sd);
      logic [15:0] l;
      logic [5:0]  t;
      int          i, m, r, guard;
      l = (sd == 16'd0) ? 16'hACE1 : sd;
      for (int k = 0; k < 108; k++) mdl[k] = canon[k];
      i = 107;
      guard = 0;
      while (i >= 1 && guard < 100000) begin
         m = 1;
         while (m < i) m = m * 2 + 1;
         r = int'(l[6:0]) & m;
         if (r <= i) begin
            t = mdl[i];
            mdl[i] = mdl[r];
            mdl[r] = t;
            i--;
         end
         l = lfsr_next(l);
         guard++;
      end
   endtask

   task automatic push_exp(input int u, input exp_t e);
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic mon_pulse(input int u);
      exp_t e;
      int   have;
      have = 0;
      if (u == 0) begin
         if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      end else begin
         if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      end
      if (have == 0) begin
         check("unexpected_pulse", {30'd0, valid[u], uflow[u]}, 32'd0);
      end else begin
         check("card", 32'(card[u]), 32'(e.card));
         check("remaining", 32'(rem[u]), 32'(e.rem));
         check("underflow", 32'(uflow[u]), 32'(e.uflow));
         check("card_valid", 32'(valid[u]), 32'(!e.uflow));
         if (u == 0) cap0.push_back(card[u]);
         else cap1.push_back(card[u]);
      end
   endtask

   // Outputs are sampled mid-cycle, well away from the rising edge.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (valid[u] || uflow[u]) mon_pulse(u);
      end
   end

   task automatic do_start(input int u, input logic [15:0] sd);
      seed[u]  = sd;
      start[u] = 1'b1;
      @(posedge clk);
      #1;
      start[u] = 1'b0;
      check("start_busy", 32'(busy[u]), 32'd1);
      check("start_remaining", 32'(rem[u]), 32'd0);
      check("start_card", 32'(card[u]), 32'h3F);
      check("start_ready", 32'(ready[u]), 32'd0);
   endtask

   task automatic wait_ready(input int u, output int n);
      n = 0;
      while (!ready[u] && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ready_reached", 32'(ready[u]), 32'd1);
   endtask

   function automatic int qsize(input int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction

   // Start, wait for READY, then draw the whole pile back to back.
   task automatic deal(input int u, input logic [15:0] sd);
      exp_t e;
      int   n;
      if (u == 1) run_model(sd);
      if (u == 0) cap0.delete();
      else cap1.delete();
      do_start(u, sd);
      wait_ready(u, n);
      if (u == 0) check("fill_cycles", n, 108);
      check("remaining_full", 32'(rem[u]), 32'd108);
      check("busy_in_ready", 32'(busy[u]), 32'd0);
      for (int k = 0; k < 108; k++) begin
         e.uflow = 1'b0;
         e.rem   = 7'(107 - k);
         e.card  = (u == 0) ? canon[107 - k] : mdl[107 - k];
         push_exp(u, e);
         draw[u] = 1'b1;
         @(posedge clk);
         #1;
      end
      draw[u] = 1'b0;
      @(posedge clk);
      #1;
      check("pending_expect", qsize(u), 0);
   endtask

   function automatic int count_diff(input int a, input int b);
      int d;
      d = 0;
      for (int k = 0; k < 108; k++) if (seq[a][k] !== seq[b][k]) d++;
      return d;
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[10];
      logic [15:0] seeds[5];
      exp_t        e;
      int          p, n, d;
      int          hg[64];
      int          hc[64];

      vt[0] = '{1,   6'b001110};
      vt[1] = '{4,   6'b001110};
      vt[2] = '{5,   6'b001101};
      vt[3] = '{8,   6'b001101};
      vt[4] = '{9,   6'b111100};
      vt[5] = '{83,  6'b010000};
      vt[6] = '{84,  6'b001100};
      vt[7] = '{101, 6'b000100};
      vt[8] = '{107, 6'b000001};
      vt[9] = '{108, 6'b000000};
      seeds[0] = 16'h1234;
      seeds[1] = 16'h1234;
      seeds[2] = 16'h5678;
      seeds[3] = 16'h0000;
      seeds[4] = 16'hACE1;

      p = 0;
      for (int c = 0; c < 4; c++) begin
         canon[p] = {2'(c), 4'd0};
         p++;
         for (int v = 1; v <= 12; v++) begin
            canon[p] = {2'(c), 4'(v)}; p++;
            canon[p] = {2'(c), 4'(v)}; p++;
         end
      end
      for (int k = 0; k < 4; k++) begin canon[p] = 6'b001101; p++; end
      for (int k = 0; k < 4; k++) begin canon[p] = 6'b001110; p++; end

      // Reset values on both instances.
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         check("rst_card", 32'(card[u]), 32'h3F);
         check("rst_remaining", 32'(rem[u]), 32'd0);
         check("rst_ready", 32'(ready[u]), 32'd0);
         check("rst_busy", 32'(busy[u]), 32'd0);
         check("rst_valid", 32'(valid[u]), 32'd0);
         check("rst_underflow", 32'(uflow[u]), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      // Draw in IDLE: ignored, no pulse of either kind.
      draw = 2'b11;
      @(posedge clk);
      #1;
      draw = 2'b00;
      @(posedge clk);
      #1;
      check("idle_draw_remaining", 32'(rem[0]), 32'd0);
      check("idle_draw_card", 32'(card[1]), 32'h3F);

      // Unshuffled pile: draws come out in reverse canonical order.
      deal(0, 16'h1234);
      for (int j = 0; j < 10; j++) begin
         if (cap0.size() >= vt[j].n) check($sformatf("canon_draw_%0d", vt[j].n),
                                            32'(cap0[vt[j].n - 1]), 32'(vt[j].card));
         else check("canon_capture_count", cap0.size(), 108);
      end
      check("card_held", 32'(card[0]), 32'h00);

      // Empty pile: underflow pulse, card cleared, count stays 0; restart refills.
      e.uflow = 1'b1;
      e.card  = 6'h3F;
      e.rem   = 7'd0;
      push_exp(0, e);
      draw[0] = 1'b1;
      @(posedge clk);
      #1;
      draw[0] = 1'b0;
      @(posedge clk);
      #1;
      check("underflow_seen", q0.size(), 0);
      check("underflow_card_held", 32'(card[0]), 32'h3F);
      check("underflow_ready", 32'(ready[0]), 32'd1);
      do_start(0, 16'h0000);
      wait_ready(0, n);
      check("refill_remaining", 32'(rem[0]), 32'd108);

      // Draw during FILL is ignored.
      do_start(1, 16'h1234);
      draw[1] = 1'b1;
      @(posedge clk);
      #1;
      draw[1] = 1'b0;
      check("fill_draw_remaining", 32'(rem[1]), 32'd0);
      check("fill_draw_busy", 32'(busy[1]), 32'd1);

      // Shuffled deals over a seed table.
      for (int j = 0; j < 5; j++) begin
         deal(1, seeds[j]);
         for (int k = 0; k < 108; k++) seq[j][k] = (k < cap1.size()) ? cap1[k] : 6'h3F;
      end
      check("seed_repeatable", count_diff(0, 1), 0);
      d = count_diff(0, 2);
      check("seed_5678_differs", 32'(d != 0), 32'd1);
      check("seed_zero_is_default", count_diff(3, 4), 0);

      // Shuffled multiset equals the canonical one.
      for (int c = 0; c < 64; c++) begin hg[c] = 0; hc[c] = 0; end
      for (int k = 0; k < 108; k++) begin
         hg[seq[0][k]]++;
         hc[canon[k]]++;
      end
      for (int c = 0; c < 64; c++) check($sformatf("multiset_%02h", c), hg[c], hc[c]);

      // Start and draw in the same cycle while READY: start wins, no pulse.
      run_model(16'h1234);
      do_start(1, 16'h1234);
      wait_ready(1, n);
      e.uflow = 1'b0;
      e.card  = mdl[107];
      e.rem   = 7'd107;
      push_exp(1, e);
      draw[1] = 1'b1;
      @(posedge clk);
      #1;
      draw[1]  = 1'b0;
      @(posedge clk);
      #1;
      check("single_draw_card", 32'(card[1]), 32'(mdl[107]));
      start[1] = 1'b1;
      draw[1]  = 1'b1;
      @(posedge clk);
      #1;
      start[1] = 1'b0;
      draw[1]  = 1'b0;
      check("start_draw_remaining", 32'(rem[1]), 32'd0);
      check("start_draw_busy", 32'(busy[1]), 32'd1);
      check("start_draw_card", 32'(card[1]), 32'h3F);
      @(posedge clk);
      #1;
      check("start_draw_no_valid", 32'(valid[1]), 32'd0);

      // Restart from the middle of SHUFFLE and deal the new seed.
      repeat (115) @(posedge clk);
      #1;
      check("mid_shuffle_busy", 32'(busy[1]), 32'd1);
      check("mid_shuffle_ready", 32'(ready[1]), 32'd0);
      deal(1, 16'h5678);

      // Asynchronous reset in the middle of SHUFFLE.
      do_start(1, 16'h1234);
      repeat (115) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_card", 32'(card[1]), 32'h3F);
      check("arst_remaining", 32'(rem[1]), 32'd0);
      check("arst_busy", 32'(busy[1]), 32'd0);
      check("arst_ready", 32'(ready[1]), 32'd0);
      check("arst_valid", 32'(valid[1]), 32'd0);
      check("arst_underflow", 32'(uflow[1]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      draw[1] = 1'b1;
      @(posedge clk);
      #1;
      draw[1] = 1'b0;
      @(posedge clk);
      #1;
      check("arst_idle_ready", 32'(ready[1]), 32'd0);
      check("final_queues_empty", q0.size() + q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uno_deck_dealer.md
Name: uno_deck_dealer

Overview:
Upstream card source for the UNO game logic and the hand/display path. Holds the 108-card draw pile, builds it in canonical order, shuffles it in place using Fisher-Yates with an LFSR, then serves one card per draw request. Game control issues draws when dealing and on player/computer draw actions. Dealt cards go into the 6-bit hand slots consumed by Display.

Parameters:
DECK_SIZE, 108, number of cards in a full deck.
CARD_W, 6, card code width: [5:4] colour, [3:0] value.
LFSR_W, 16, shuffle random source width.
DEFAULT_SEED, 16'hACE1, seed used when i_seed is 0.
SHUFFLE_EN, 1, 0 skips shuffling (pile stays canonical; test use).

Ports:
i_clk  in  1  system clock (1 MHz game clock domain)
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle pulse: rebuild and reshuffle the pile
i_seed  in  16  LFSR seed, sampled on i_start
i_draw  in  1  one-cycle pulse: pop the top card
o_card  out  6  last drawn card; 6'h3F = none
o_card_valid  out  1  one-cycle pulse, o_card holds a newly drawn card
o_underflow  out  1  one-cycle pulse, draw requested while the pile is empty
o_remaining  out  7  cards left in the pile, 0..108
o_busy  out  1  high during FILL/SHUFFLE
o_ready  out  1  high in READY

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_card=6'h3F; o_card_valid=0; o_underflow=0; o_remaining=0; o_busy=0; o_ready=0; lfsr=DEFAULT_SEED; pile contents don't-care.
- Card values: 0-9 number, 10 skip, 11 reverse, 12 draw-two, 13 wild, 14 wild-draw-four, 15 reserved.
- Canonical order, index k: colours 0..3 each take 25 entries: 0, 1,1, 2,2 ... 9,9, 10,10, 11,11, 12,12. Then k=100..103 hold 6'b001101, and k=104..107 hold 6'b001110.
- FSM states: IDLE, FILL, SHUFFLE, READY.
- IDLE: waits for i_start.
- i_start in any state goes to FILL. It loads the LFSR with i_seed, or DEFAULT_SEED if i_seed is 0. It sets fill_idx=0, o_remaining=0 and o_busy=1. i_start wins over a same-cycle i_draw.
- FILL: writes pile[fill_idx]=canonical(fill_idx), one entry per cycle, 108 cycles.
  - After index 107, if SHUFFLE_EN: go to SHUFFLE with i=107.
  - Otherwise go to READY.
- SHUFFLE: the LFSR advances every cycle.
  - Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - r = lfsr[6:0] & mask(i), where mask(i) = smallest 2^k-1 that is >= i.
  - If r <= i: swap pile[i] and pile[r], then i = i-1.
  - Otherwise retry next cycle with no write.
  - When the swap at i=1 completes, go to READY.
- Entering READY: o_remaining=108, o_busy=0, o_ready=1.
- READY + i_draw with o_remaining>0: next cycle o_card=pile[o_remaining-1], o_card_valid=1, o_remaining decrements. Latency 1 cycle. Back-to-back draws every cycle are supported.
- READY + i_draw with o_remaining=0: next cycle o_underflow=1, o_card=6'h3F, o_card_valid=0, state unchanged.
- i_draw in IDLE/FILL/SHUFFLE is ignored, with no pulse.
- o_card holds its value between draws. It is set to 6'h3F on i_start.
- Reset during FILL/SHUFFLE aborts the operation and returns everything to reset values.

Decomposition:
- Package uno_pkg holds:
  - card_t (6-bit) with colour/value fields;
  - value constants for SKIP, REV, DRAW2, WILD, WILD4;
  - CARD_NONE = 6'h3F;
  - DECK_SIZE;
  - function canonical_card(idx).
- Package uno_pkg is shared with the Uno controller and Display.
- One sub-module: uno_lfsr16. It takes load/seed/enable inputs and produces a 16-bit state. It is reusable for computer-player choices.

Test Plan:
- Reset -> o_card=6'h3F, o_remaining=0, o_ready=0, o_busy=0. i_draw gives no valid pulse and no underflow.
- SHUFFLE_EN=0, i_start -> o_ready after 108 fill cycles. Issue 108 draws: first card 6'b001110, draw 5 = 6'b001101, draw 9 = 6'b111100. The sequence is canonical order reversed.
- SHUFFLE_EN=1, seed 16'h1234, 108 draws -> the multiset matches canonical exactly. Per colour: one 0, two each of 1..12. Four 6'b001101 and four 6'b001110. o_remaining steps 108->0.
- Seed 16'h1234 twice -> identical sequences. Seed 16'h5678 -> a different sequence. Seed 0 -> same as seed 16'hACE1.
- Pile empty, i_draw -> o_underflow pulse, o_card=6'h3F, o_remaining=0. A subsequent i_start refills to 108.
- Mid-operation events:
  - i_start during SHUFFLE restarts FILL, o_remaining=0, with no valid pulse.
  - i_draw in the same cycle as i_start is ignored.
  - i_rst asserted mid-SHUFFLE returns all outputs to reset values.
